// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
//   Shared definitions for the ID stage of the 16-bit pipelined core:
//   datapath/register-ID widths, opcode map, immediate kinds, the decoded
//   instruction bundle and the ID/EX pipeline-register layout.
//   No ports (package).
// ---------------------------------------------------------------------------
package decode_stage_pkg;

  localparam int DW = 16;  // datapath width
  localparam int RW = 4;   // register-ID width (16 GPRs)

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE,    // 0
    IMM_MEM,     // sext(instr[3:0]) << 1
    IMM_SHIFT,   // zext(instr[3:0])
    IMM_BYTE,    // zext(instr[7:0])
    IMM_BRANCH   // sext(instr[8:0]) << 1
  } imm_kind_e;

  // Output of the combinational instruction decoder.
  typedef struct packed {
    logic [RW-1:0] src1;    // read ID 1 (0 when not used)
    logic [RW-1:0] src2;    // read ID 2 (0 when not used)
    logic          use1;    // src1 is a real operand dependency
    logic          use2;    // src2 is a real operand dependency
    logic [DW-1:0] imm;
    logic          regwr;
    logic          memrd;
    logic          memwr;
    logic          halt;
  } dec_t;

  // ID/EX pipeline register contents. All-zero is a bubble.
  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc2;
    logic          regwr;
    logic          memrd;
    logic          memwr;
    logic          halt;
  } idex_t;

  // Only the low nine instruction bits ever feed an immediate.
  function automatic logic [DW-1:0] build_imm(input imm_kind_e kind,
                                              input logic [8:0] lo);
    logic [DW-1:0] imm;
    imm = '0;
    case (kind)
      IMM_MEM:    imm = {{(DW-5){lo[3]}}, lo[3:0], 1'b0};
      IMM_SHIFT:  imm = {{(DW-4){1'b0}}, lo[3:0]};
      IMM_BYTE:   imm = {{(DW-8){1'b0}}, lo[7:0]};
      IMM_BRANCH: imm = {{(DW-10){lo[8]}}, lo[8:0], 1'b0};
      default:    imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_instr_decode.sv
// ---------------------------------------------------------------------------
// decode_stage_instr_decode
//   Purely combinational decoder: instruction word -> register read IDs,
//   used-source flags, decoded immediate and control bits.
// Ports
//   i_instr  in   16   instruction word
//   o_dec    out  dec_t  decoded bundle (see decode_stage_pkg)
// ---------------------------------------------------------------------------
module decode_stage_instr_decode
  import decode_stage_pkg::*;
(
  input  logic [DW-1:0] i_instr,
  output dec_t          o_dec
);

  opcode_e       w_op;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rs;
  logic [RW-1:0] w_rt;
  imm_kind_e     w_kind;

  assign w_op = opcode_e'(i_instr[15:12]);
  assign w_rd = i_instr[11:8];
  assign w_rs = i_instr[7:4];
  assign w_rt = i_instr[3:0];

  always_comb begin
    o_dec       = '0;
    o_dec.src1  = w_rs;
    o_dec.src2  = w_rt;
    o_dec.use1  = 1'b1;
    o_dec.use2  = 1'b1;
    w_kind      = IMM_NONE;

    case (w_op)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        o_dec.regwr = 1'b1;
      end
      // The rt field of a shift is the shift amount, not a register.
      OP_SLL, OP_SRA, OP_ROR: begin
        o_dec.regwr = 1'b1;
        o_dec.use2  = 1'b0;
        w_kind      = IMM_SHIFT;
      end
      OP_LW: begin
        o_dec.regwr = 1'b1;
        o_dec.memrd = 1'b1;
        o_dec.use2  = 1'b0;
        w_kind      = IMM_MEM;
      end
      // Store data comes from rd, so it is read through port 2.
      OP_SW: begin
        o_dec.memwr = 1'b1;
        o_dec.src2  = w_rd;
        w_kind      = IMM_MEM;
      end
      // Byte loads merge into the old rd value, so rd is read on port 1.
      OP_LLB, OP_LHB: begin
        o_dec.regwr = 1'b1;
        o_dec.src1  = w_rd;
        o_dec.use2  = 1'b0;
        w_kind      = IMM_BYTE;
      end
      OP_B: begin
        o_dec.use1  = 1'b0;
        o_dec.use2  = 1'b0;
        w_kind      = IMM_BRANCH;
      end
      OP_BR: begin
        o_dec.use2  = 1'b0;
      end
      OP_PCS: begin
        o_dec.regwr = 1'b1;
        o_dec.use1  = 1'b0;
        o_dec.use2  = 1'b0;
      end
      OP_HLT: begin
        o_dec.halt  = 1'b1;
        o_dec.use1  = 1'b0;
        o_dec.use2  = 1'b0;
      end
      default: begin
        o_dec.use1  = 1'b0;
        o_dec.use2  = 1'b0;
      end
    endcase

    // Unused ports read R0 so they never look like a dependency downstream.
    if (!o_dec.use1) o_dec.src1 = '0;
    if (!o_dec.use2) o_dec.src2 = '0;

    // R0 is hard-wired; a write to it is architecturally a no-op.
    if (w_rd == '0) o_dec.regwr = 1'b0;

    o_dec.imm = build_imm(w_kind, i_instr[8:0]);
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   ID stage of the 16-bit pipelined core. Decodes the IF/ID instruction,
//   drives register-file read IDs, captures the read data into the ID/EX
//   register, detects load-use hazards, applies flush/hold, and latches HLT.
// Ports
//   clk, rst            clock; synchronous active-low reset
//   if_id_valid/instr/pc2   IF/ID slot contents
//   flush               taken branch in EX: kill ID, load a bubble
//   hold                MEM stall: freeze ID/EX
//   rf_src1/2, rf_data1/2   register-file read IDs / data
//   stall               freeze PC and IF/ID (combinational)
//   ex_*                ID/EX register contents
//   halted              HLT has passed through ID
// ---------------------------------------------------------------------------
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          if_id_valid,
  input  logic [DW-1:0] if_id_instr,
  input  logic [DW-1:0] if_id_pc2,
  input  logic          flush,
  input  logic          hold,
  output logic [RW-1:0] rf_src1,
  output logic [RW-1:0] rf_src2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic          stall,
  output logic          ex_valid,
  output logic [3:0]    ex_op,
  output logic [RW-1:0] ex_rd,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc2,
  output logic          ex_regwr,
  output logic          ex_memrd,
  output logic          ex_memwr,
  output logic          ex_halt,
  output logic          halted
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  dec_t                w_dec;
  idex_t               r_idex;
  idex_t               w_idex_next;
  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic [1:0][RW-1:0]  w_src;
  logic [1:0]          w_use;
  logic [1:0]          w_hit;
  logic                w_loaduse;
  logic                w_load_bubble;

  decode_stage_instr_decode u_dec (
    .i_instr (if_id_instr),
    .o_dec   (w_dec)
  );

  assign rf_src1 = w_dec.src1;
  assign rf_src2 = w_dec.src2;

  assign w_src[0] = w_dec.src1;
  assign w_src[1] = w_dec.src2;
  assign w_use[0] = w_dec.use1;
  assign w_use[1] = w_dec.use2;

  // One comparator per read port against the load sitting in ID/EX.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      assign w_hit[gi] = w_use[gi] & (w_src[gi] == r_idex.rd);
    end
  endgenerate

  // A load to R0 never produces a usable value, so it cannot cause a hazard.
  assign w_loaduse = if_id_valid & r_idex.valid & r_idex.memrd &
                     (r_idex.rd != '0) & (|w_hit);

  // Once halted, nothing else may enter EX.
  assign w_load_bubble = ~if_id_valid | w_loaduse | (r_state == ST_HALTED);

  // Flush wins over everything: IF must go fetch the branch target.
  assign stall = ~flush & (hold | (r_state == ST_HALTED) | w_loaduse);

  always_comb begin
    w_idex_next  = r_idex;
    w_state_next = r_state;
    if (flush) begin
      w_idex_next = '0;
    end else if (!hold) begin
      if (w_load_bubble) begin
        w_idex_next = '0;
      end else begin
        w_idex_next.valid = 1'b1;
        w_idex_next.op    = if_id_instr[15:12];
        w_idex_next.rd    = if_id_instr[11:8];
        w_idex_next.rs    = w_dec.src1;
        w_idex_next.rt    = w_dec.src2;
        w_idex_next.a     = rf_data1;
        w_idex_next.b     = rf_data2;
        w_idex_next.imm   = w_dec.imm;
        w_idex_next.pc2   = if_id_pc2;
        w_idex_next.regwr = w_dec.regwr;
        w_idex_next.memrd = w_dec.memrd;
        w_idex_next.memwr = w_dec.memwr;
        w_idex_next.halt  = w_dec.halt;
        if (w_dec.halt) w_state_next = ST_HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idex  <= '0;
      r_state <= ST_RUN;
    end else begin
      r_idex  <= w_idex_next;
      r_state <= w_state_next;
    end
  end

  assign ex_valid = r_idex.valid;
  assign ex_op    = r_idex.op;
  assign ex_rd    = r_idex.rd;
  assign ex_rs    = r_idex.rs;
  assign ex_rt    = r_idex.rt;
  assign ex_a     = r_idex.a;
  assign ex_b     = r_idex.b;
  assign ex_imm   = r_idex.imm;
  assign ex_pc2   = r_idex.pc2;
  assign ex_regwr = r_idex.regwr;
  assign ex_memrd = r_idex.memrd;
  assign ex_memwr = r_idex.memwr;
  assign ex_halt  = r_idex.halt;
  assign halted   = (r_state == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage. Expected ID/EX slots are queued when an
//   instruction is issued; a monitor pops and compares each new valid slot.
//   Stall, bubble, hold and halt timing are checked inline.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  typedef logic [83:0] slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc2;
  logic        flush;
  logic        hold;
  logic [3:0]  rf_src1, rf_src2;
  logic [15:0] rf_data1, rf_data2;
  logic        stall;
  logic        ex_valid;
  logic [3:0]  ex_op, ex_rd, ex_rs, ex_rt;
  logic [15:0] ex_a, ex_b, ex_imm, ex_pc2;
  logic        ex_regwr, ex_memrd, ex_memwr, ex_halt;
  logic        halted;

  logic [15:0] regs [16];
  slot_t       sb [$];
  slot_t       m_exp;
  logic        hold_at_edge = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign rf_data1 = regs[rf_src1];
  assign rf_data2 = regs[rf_src2];

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc2(if_id_pc2),
    .flush(flush), .hold(hold),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .stall(stall),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc2(ex_pc2),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_halt(ex_halt),
    .halted(halted)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic slot_t mk(input logic [3:0] op, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] imm, input logic [15:0] pc2,
                               input logic regwr, input logic memrd,
                               input logic memwr, input logic halt);
    return {op, rd, rs, rt, a, b, imm, pc2, regwr, memrd, memwr, halt};
  endfunction

  task automatic setin(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic fl, input logic hd);
    if_id_valid = v;
    if_id_instr = ins;
    if_id_pc2   = pc;
    flush       = fl;
    hold        = hd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every fresh valid slot (not one merely held) must match the queue head.
  always @(posedge clk) hold_at_edge <= hold;

  always @(negedge clk) begin
    if (ex_valid === 1'b1 && hold_at_edge !== 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_slot: got op %0h pc2 %0h required no valid slot", ex_op, ex_pc2);
      end else begin
        m_exp = sb.pop_front();
        chk("exslot", {ex_op, ex_rd, ex_rs, ex_rt, ex_a, ex_b, ex_imm, ex_pc2,
                       ex_regwr, ex_memrd, ex_memwr, ex_halt}, m_exp);
        $display("slot op=%0h rd=%0h a=%0h b=%0h imm=%0h pc2=%0h", ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] t_ins [6];
    slot_t       t_exp [6];

    for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h0011);
    regs[1] = 16'd5;
    regs[2] = 16'd7;

    // ---- reset ----
    rst = 1'b0;
    setin(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset_valid",  ex_valid, 0);
    chk("reset_halted", halted, 0);
    chk("reset_regwr",  ex_regwr, 0);
    chk("reset_a",      ex_a, 0);
    chk("reset_stall",  stall, 0);
    next_cycle();
    rst = 1'b1;

    // ---- 1: ADD R3,R1,R2 ----
    setin(1'b1, 16'h0312, 16'h0102, 1'b0, 1'b0);
    sb.push_back(mk(4'h0, 4'd3, 4'd1, 4'd2, 16'd5, 16'd7, 16'h0, 16'h0102, 1, 0, 0, 0));
    @(negedge clk);
    chk("t1_src1", rf_src1, 1);
    chk("t1_src2", rf_src2, 2);
    chk("t1_stall", stall, 0);
    next_cycle();

    // ---- 2: LW R4,[R1+2] then ADD R5,R4,R2 ----
    setin(1'b1, 16'h8411, 16'h0104, 1'b0, 1'b0);
    sb.push_back(mk(4'h8, 4'd4, 4'd1, 4'd0, 16'd5, 16'h0, 16'h0002, 16'h0104, 1, 1, 0, 0));
    @(negedge clk);
    next_cycle();
    setin(1'b1, 16'h0542, 16'h0106, 1'b0, 1'b0);
    sb.push_back(mk(4'h0, 4'd5, 4'd4, 4'd2, 16'h0044, 16'd7, 16'h0, 16'h0106, 1, 0, 0, 0));
    @(negedge clk);
    chk("t2_stall", stall, 1);
    next_cycle();
    @(negedge clk);
    chk("t2_bubble", ex_valid, 0);
    chk("t2_stall_drop", stall, 0);
    next_cycle();

    // ---- 3: LW R0 then ADD R5,R0,R2 ----
    setin(1'b1, 16'h8010, 16'h0108, 1'b0, 1'b0);
    sb.push_back(mk(4'h8, 4'd0, 4'd1, 4'd0, 16'd5, 16'h0, 16'h0, 16'h0108, 0, 1, 0, 0));
    @(negedge clk);
    next_cycle();
    setin(1'b1, 16'h0502, 16'h010A, 1'b0, 1'b0);
    sb.push_back(mk(4'h0, 4'd5, 4'd0, 4'd2, 16'h0, 16'd7, 16'h0, 16'h010A, 1, 0, 0, 0));
    @(negedge clk);
    chk("t3_stall", stall, 0);
    next_cycle();

    // ---- 4: load-use hazard coinciding with flush ----
    setin(1'b1, 16'h8411, 16'h010C, 1'b0, 1'b0);
    sb.push_back(mk(4'h8, 4'd4, 4'd1, 4'd0, 16'd5, 16'h0, 16'h0002, 16'h010C, 1, 1, 0, 0));
    @(negedge clk);
    next_cycle();
    setin(1'b1, 16'h0542, 16'h010E, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_stall_flush", stall, 0);
    next_cycle();
    setin(1'b1, 16'h0612, 16'h0200, 1'b0, 1'b0);
    sb.push_back(mk(4'h0, 4'd6, 4'd1, 4'd2, 16'd5, 16'd7, 16'h0, 16'h0200, 1, 0, 0, 0));
    @(negedge clk);
    chk("t4_bubble", ex_valid, 0);
    chk("t4_stall_target", stall, 0);
    next_cycle();

    // ---- 5: SW R3,[R2-2] then hold for 3 cycles with LLB waiting ----
    setin(1'b1, 16'h932F, 16'h0202, 1'b0, 1'b0);
    sb.push_back(mk(4'h9, 4'd3, 4'd2, 4'd3, 16'd7, 16'h0033, 16'hFFFE, 16'h0202, 0, 0, 1, 0));
    @(negedge clk);
    chk("t4_no_extra_bubble", ex_valid, 1);
    chk("t4_target_rd", ex_rd, 6);
    next_cycle();
    setin(1'b1, 16'hA7AB, 16'h0204, 1'b0, 1'b1);
    sb.push_back(mk(4'hA, 4'd7, 4'd7, 4'd0, 16'h0077, 16'h0, 16'h00AB, 16'h0204, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_stall", stall, 1);
      chk("t5_hold_valid", ex_valid, 1);
      chk("t5_hold_op",    ex_op, 4'h9);
      chk("t5_hold_imm",   ex_imm, 16'hFFFE);
      chk("t5_hold_b",     ex_b, 16'h0033);
      next_cycle();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("t5_release_stall", stall, 0);
    next_cycle();

    // ---- immediate / source-selection table ----
    t_ins[0] = 16'h512F;  // SRA R1,R2,15
    t_exp[0] = mk(4'h5, 4'd1, 4'd2, 4'd0, 16'd7, 16'h0, 16'h000F, 16'h0206, 1, 0, 0, 0);
    t_ins[1] = 16'hC100;  // B with most-negative offset
    t_exp[1] = mk(4'hC, 4'd1, 4'd0, 4'd0, 16'h0, 16'h0, 16'hFE00, 16'h0208, 0, 0, 0, 0);
    t_ins[2] = 16'hB0FF;  // LHB R0,0xFF
    t_exp[2] = mk(4'hB, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h00FF, 16'h020A, 0, 0, 0, 0);
    t_ins[3] = 16'hE900;  // PCS R9
    t_exp[3] = mk(4'hE, 4'd9, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h020C, 1, 0, 0, 0);
    t_ins[4] = 16'hD250;  // BR cond 2, R5
    t_exp[4] = mk(4'hD, 4'd2, 4'd5, 4'd0, 16'h0055, 16'h0, 16'h0, 16'h020E, 0, 0, 0, 0);
    t_ins[5] = 16'h2834;  // XOR R8,R3,R4
    t_exp[5] = mk(4'h2, 4'd8, 4'd3, 4'd4, 16'h0033, 16'h0044, 16'h0, 16'h0210, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      setin(1'b1, t_ins[i], 16'(16'h0206 + 2 * i), 1'b0, 1'b0);
      sb.push_back(t_exp[i]);
      @(negedge clk);
      chk("tab_stall", stall, 0);
      next_cycle();
    end

    // ---- 6: HLT then ADD ----
    setin(1'b1, 16'hF000, 16'h0300, 1'b0, 1'b0);
    sb.push_back(mk(4'hF, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0300, 0, 0, 0, 1));
    @(negedge clk);
    next_cycle();
    setin(1'b1, 16'h0312, 16'h0302, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_ex_halt", ex_halt, 1);
    chk("t6_halted", halted, 1);
    chk("t6_stall", stall, 1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_valid", ex_valid, 0);
      chk("t6_halt_once", ex_halt, 0);
      chk("t6_still_halted", halted, 1);
      chk("t6_stall_forever", stall, 1);
      next_cycle();
    end
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    setin(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_rst_halted", halted, 0);
    chk("t6_rst_valid", ex_valid, 0);
    chk("t6_rst_stall", stall, 0);
    next_cycle();

    repeat (2) next_cycle();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
